// File: rtl/state_mgr_pkg.sv
// Shared definitions for the state manager's Ethernet response path:
// frame constants, field widths and the transmitter state encoding.
package state_mgr_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hD7;
  localparam int unsigned FRAME_LEN   = 6;
  localparam int unsigned CMD_W       = 4;
  localparam int unsigned STATE_W     = 4;
  localparam int unsigned FIFO_USED_W = 11;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } tx_state_e;

endpackage

// File: rtl/eth_resp_tx.sv
// Ethernet response transmitter: captures one status-report request and streams it
// out as a fixed 6-byte frame on a valid/ready/last byte interface.
module eth_resp_tx
  import state_mgr_pkg::*;
#(
  parameter logic [7:0] SyncByte = SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CMD_W-1:0]       req_cmd,
  input  logic [STATE_W-1:0]     req_state,
  input  logic [FIFO_USED_W-1:0] req_fifo_used,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   tx_last
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

  tx_state_e              r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [CMD_W-1:0]       r_cmd;
  logic [STATE_W-1:0]     r_sys_state;
  logic [FIFO_USED_W-1:0] r_fifo_used;
  logic [7:0]             r_seq;
  logic [7:0]             r_chk;
  logic [7:0]             r_tx_data;
  logic                   r_tx_valid;
  logic                   r_tx_last;
  logic                   r_req_ready;

  logic       w_accept;
  logic       w_xfer;
  logic [7:0] w_chk_in;
  logic [7:0] w_next_byte;

  assign w_accept = req_valid && r_req_ready;
  assign w_xfer   = r_tx_valid && tx_ready;

  // Checksum built from the live request at accept time, so it matches the captured fields.
  assign w_chk_in = SyncByte ^ {req_cmd, req_state} ^ {5'b0, req_fifo_used[10:8]} ^
                    req_fifo_used[7:0] ^ r_seq;

  // Byte that follows the one currently on tx_data (i.e. byte[r_idx + 1]).
  always_comb begin
    w_next_byte = 8'h00;
    case (r_idx)
      3'd0:    w_next_byte = {r_cmd, r_sys_state};
      3'd1:    w_next_byte = {5'b0, r_fifo_used[10:8]};
      3'd2:    w_next_byte = r_fifo_used[7:0];
      3'd3:    w_next_byte = r_seq;
      3'd4:    w_next_byte = r_chk;
      default: w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_cmd       <= '0;
      r_sys_state <= '0;
      r_fifo_used <= '0;
      r_seq       <= 8'h00;
      r_chk       <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_cmd       <= req_cmd;
            r_sys_state <= req_state;
            r_fifo_used <= req_fifo_used;
            r_chk       <= w_chk_in;
            r_idx       <= '0;
            r_tx_data   <= SyncByte;
            r_tx_valid  <= 1'b1;
            r_tx_last   <= 1'b0;
            r_req_ready <= 1'b0;
            r_state     <= StSend;
          end
        end
        StSend: begin
          if (w_xfer) begin
            if (r_idx == LastIdx) begin
              r_seq       <= r_seq + 8'd1;
              r_tx_data   <= 8'h00;
              r_tx_valid  <= 1'b0;
              r_tx_last   <= 1'b0;
              r_req_ready <= 1'b1;
              r_state     <= StIdle;
            end else begin
              r_idx     <= r_idx + 3'd1;
              r_tx_data <= w_next_byte;
              r_tx_last <= (r_idx == LastIdx - 3'd1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_last   = r_tx_last;

endmodule

// File: doc/eth_resp_tx.md
# eth_resp_tx

Ethernet response transmitter: the transmit-side counterpart to the state manager's receive-side packet parser. Accepts one status-report request at a time from the state manager, serialises it into a fixed 6-byte response frame, and drives it byte-by-byte toward the Ethernet MAC on a valid/ready/last byte stream. Runs in the 125 MHz Ethernet clock domain.

## Interface
- SYNC_BYTE, 8'hD7, constant first byte of every frame
- clk  in  1  Ethernet clock, 125 MHz; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  state manager presents a report request
- req_ready  out  1  block can accept a request
- req_cmd  in  4  command nibble being answered
- req_state  in  4  current system state
- req_fifo_used  in  11  video-out FIFO used-words snapshot
- tx_data  out  8  frame byte to MAC
- tx_valid  out  1  tx_data holds a valid byte
- tx_ready  in  1  MAC accepts the byte this cycle
- tx_last  out  1  current byte is the final byte of the frame

## Operation
- Request accepted when req_valid && req_ready; req_cmd, req_state, req_fifo_used captured into registers that cycle; later input changes have no effect on the frame.
- Frame bytes, in order: B0 = SYNC_BYTE; B1 = {req_cmd, req_state}; B2 = {5'b0, fifo_used[10:8]}; B3 = fifo_used[7:0]; B4 = seq (8-bit frame counter); B5 = B0^B1^B2^B3^B4.
- FSM states: IDLE, SEND.
  - IDLE: req_ready=1, tx_valid=0. On accept -> SEND, byte index = 0.
  - SEND: req_ready=0, tx_valid=1, tx_data = byte[index]. On tx_valid && tx_ready: if index<5, index+1; if index==5, seq+1 and -> IDLE.
- tx_last = 1 exactly while in SEND with index==5.
- seq: 8-bit, increments only on completion of B5's handshake; wraps 8'hFF -> 8'h00. First frame after reset carries seq=0.
- Checksum is XOR computed on captured values; it is never affected by tx_ready stalls.
- Reset mid-frame: frame abandoned; no tx_last emitted; seq returns to 0.

## Timing
- Reset values: req_ready=1, tx_valid=0, tx_last=0, tx_data=8'h00, seq=0, state IDLE.
- Latency: request accepted in cycle N -> tx_valid=1 with B0 in cycle N+1.
- Stream rule: while tx_valid && !tx_ready, tx_data/tx_last are held unchanged; tx_valid never drops mid-frame except on rst.
- With tx_ready held high: B0..B5 in cycles N+1..N+6; IDLE (req_ready=1) in N+7; next B0 no earlier than N+8. Minimum frame period 7 cycles.
- req_valid asserted during SEND is ignored (not captured); the requester holds it until req_ready.
- tx_ready asserted while tx_valid=0 has no effect.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package (state_mgr_pkg): SYNC_BYTE default, FRAME_LEN=6, state encoding for IDLE/SEND, response field widths (CMD_W=4, STATE_W=4, FIFO_USED_W=11).
- Single module, no sub-module; byte selection is a 6-way mux on the index register, checksum is a registered XOR of captured fields.

## Test plan
- Basic frame: after reset, req cmd=1, state=1, fifo_used=11'h123, tx_ready=1 -> bytes D7,11,01,23,00,E4 in 6 consecutive cycles, tx_last only on E4, first byte one cycle after accept.
- Backpressure: same request, tx_ready toggled 1,0,0,1,0,1... -> identical byte sequence, tx_data/tx_last stable through every stall, total transfers = 6.
- Sequence wrap: 257 back-to-back frames -> B4 runs 00..FF then 00; checksum correct on every frame; req_ready low throughout each SEND.
- Request during SEND: second req_valid pulse with different fields while frame 1 is in flight -> ignored; request held until IDLE is captured and sent next with seq=1.
- Reset mid-frame: rst asserted after B2 handshake -> next cycle tx_valid=0, req_ready=1; next frame starts at D7 with seq=00 and no stray tx_last.
- Max field: fifo_used=11'h7FF, cmd=F, state=F -> bytes D7,FF,07,FF,seq, checksum = D7^FF^07^FF^seq.
